tmds_encoder_pipe: RTL and testbench
====================================

Name: tmds_encoder_pipe

Overview:
- Parametrised, pipelined, multi-channel TMDS encoder producing 10-bit symbols.
- Per channel: transition minimization to a 9-bit q_m, then DC balancing with a per-channel running-disparity counter, or a control token during blanking.
- Sits between the pixel data buffer and the serializers; one channel per colour lane.

Parameters:
- CHANNELS, 3, number of independent lanes encoded in parallel.
- CNT_W, 5, width of each signed running-disparity counter (range -16..+15, sufficient for the TMDS bound).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid this cycle.
- in_mode  input  1  0 = video data, 1 = control period.
- in_data  input  CHANNELS*8  pixel bytes; lane k at [8k+7:8k].
- in_ctrl  input  CHANNELS*2  control bits {C1,C0} per lane; lane k at [2k+1:2k].
- out_valid  output  1  out_data holds a new symbol.
- out_data  output  CHANNELS*10  encoded symbols; lane k at [10k+9:10k], bit 0 transmitted first.
- out_disp  output  CHANNELS*CNT_W  current signed disparity per lane, for observability.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_disp=0; all pipeline valid flags cleared; in-flight words discarded.
- Latency: exactly 2 cycles from a sampled in_valid=1 to out_valid=1. No backpressure; the pipeline advances every cycle.
- Stage A register, per lane:
  - n1_d = popcount(in_data byte).
  - If n1_d>4, or n1_d==4 with D[0]==0: q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Otherwise the same chain with XOR, q_m[8]=1.
  - Also register n1 = popcount(q_m[7:0]) (4 bits), mode, ctrl and valid.
- Stage B, video, valid=1 (n0 = 8-n1; arithmetic signed, CNT_W bits):
  - cnt==0 or n1==n0: out[9]=~q_m[8]; out[8]=q_m[8]; out[7:0]=q_m[8] ? q_m[7:0] : ~q_m[7:0]. cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out={1,q_m[8],~q_m[7:0]}; cnt += 2*q_m[8] + (n0-n1).
  - Else: out={0,q_m[8],q_m[7:0]}; cnt += (n1-n0) - 2*(~q_m[8]).
- Stage B, control, valid=1: cnt forced to 0. Token by {C1,C0}:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- Stage B, valid=0 (bubble): out_valid=0; out_data and cnt hold their previous values.
- Lanes are fully independent; each has its own counter.
- Mode changes between consecutive valid words need no gap; a control word zeroes cnt on the same edge its token is output.

Decomposition:
- tmds_pkg holds:
  - mode enum (MODE_VIDEO=0, MODE_CTRL=1);
  - the four control-token localparams;
  - a popcount8 function;
  - a tmds_minimize function (8 -> 9 bits).
- Sub-module tmds_lane_enc holds one lane's stage A/B registers and disparity counter. It is instantiated CHANNELS times via generate. The top level holds only the shared valid/mode pipeline and port slicing.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_disp=0 throughout, and for 2 cycles after release if in_valid=0.
- Control: cycle 0 in_mode=1, lane0 ctrl=00, lane1=01, lane2=11 -> cycle 2 out_valid=1; lanes = 1101010100, 0010101011, 1010101011; all disp=0.
- Video, from disp 0: lane0=0x00, lane1=0xFF on consecutive cycles.
  - Lane0: 0100000000 (disp -8), then 1111111111 (disp +2).
  - Lane1 first word: 1000000000 (disp -8).
- Bubble: valid 0x00, in_valid=0 for 3 cycles, valid 0x00 -> out_valid low for 3 cycles; disp stays -8 across the gap; second symbol 1111111111.
- Control after video: disp=-8, then control word -> disp=0 on the token's cycle; following 0x00 encodes to 0100000000.
- Reset mid-stream: two valid words in flight, assert rst one cycle -> neither emerges; out_valid=0; all disp=0 the next cycle.

Source files
------------

// File: rtl/tmds_encoder_pipe_pkg.sv
// Shared types, control tokens and the per-byte helpers of the TMDS encoder.
// The transition-minimisation function is shared by every lane's first stage.
package tmds_pkg;

  typedef enum logic {
    MODE_VIDEO = 1'b0,
    MODE_CTRL  = 1'b1
  } tmds_mode_e;

  // Tokens are written MSB first; bit 0 goes out on the wire first.
  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, d[i]};
    end
    return c;
  endfunction

  function automatic logic [8:0] tmds_minimize(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = popcount8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_00;
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      default: t = TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_pipe_if.sv
// Pixel-side word bus and symbol-side output bus of the TMDS encoder.
// The source drives the in_* side; the encoder drives the out_* side.
interface tmds_encoder_pipe_if #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 5
);

  logic                        in_valid;
  logic                        in_mode;
  logic [CHANNELS*8-1:0]       in_data;
  logic [CHANNELS*2-1:0]       in_ctrl;
  logic                        out_valid;
  logic [CHANNELS*10-1:0]      out_data;
  logic [CHANNELS*CNT_W-1:0]   out_disp;

  modport master (
    output in_valid,
    output in_mode,
    output in_data,
    output in_ctrl,
    input  out_valid,
    input  out_data,
    input  out_disp
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_data,
    input  in_ctrl,
    output out_valid,
    output out_data,
    output out_disp
  );

endinterface

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: transition minimisation, then DC balancing against this lane's
// own running disparity, or a control token that clears the disparity.
module tmds_lane_enc
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              data,
  input  logic [1:0]              ctrl,
  input  logic                    vld_p0,
  input  tmds_mode_e              mode_p0,
  output logic [9:0]              sym,
  output logic signed [CNT_W-1:0] disp
);

  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic signed [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] CNT_8    = CNT_W'(8);

  logic [8:0]              q_m_a;
  logic [8:0]              q_m_p0;
  logic [3:0]              n1_p0;
  logic [1:0]              ctrl_p0;
  logic [9:0]              sym_p1;
  logic signed [CNT_W-1:0] cnt_p1;
  logic [9:0]              sym_nxt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] n1_s;
  logic signed [CNT_W-1:0] n0_s;
  logic signed [CNT_W-1:0] bal;
  logic signed [CNT_W-1:0] two_q8;
  logic signed [CNT_W-1:0] two_nq8;

  assign q_m_a = tmds_minimize(data);

  // ---- stage A: minimised word and its ones count ----
  always_ff @(posedge clk) begin
    q_m_p0  <= q_m_a;
    n1_p0   <= popcount8(q_m_a[7:0]);
    ctrl_p0 <= ctrl;
  end

  // bal is n1 - n0 of q_m[7:0]; the three balancing branches reuse it with sign flips.
  always_comb begin
    n1_s    = CNT_W'(n1_p0);
    n0_s    = CNT_8 - n1_s;
    bal     = n1_s - n0_s;
    two_q8  = q_m_p0[8] ? CNT_TWO : CNT_ZERO;
    two_nq8 = q_m_p0[8] ? CNT_ZERO : CNT_TWO;
    sym_nxt = sym_p1;
    cnt_nxt = cnt_p1;
    if (vld_p0) begin
      if (mode_p0 == MODE_CTRL) begin
        sym_nxt = ctrl_token(ctrl_p0);
        cnt_nxt = CNT_ZERO;
      end else if ((cnt_p1 == CNT_ZERO) || (n1_p0 == 4'd4)) begin
        sym_nxt = {~q_m_p0[8], q_m_p0[8], q_m_p0[8] ? q_m_p0[7:0] : ~q_m_p0[7:0]};
        cnt_nxt = q_m_p0[8] ? (cnt_p1 + bal) : (cnt_p1 - bal);
      end else if (((cnt_p1 > CNT_ZERO) && (n1_p0 > 4'd4)) ||
                   ((cnt_p1 < CNT_ZERO) && (n1_p0 < 4'd4))) begin
        sym_nxt = {1'b1, q_m_p0[8], ~q_m_p0[7:0]};
        cnt_nxt = cnt_p1 + two_q8 - bal;
      end else begin
        sym_nxt = {1'b0, q_m_p0[8], q_m_p0[7:0]};
        cnt_nxt = cnt_p1 + bal - two_nq8;
      end
    end
  end

  // ---- stage B: output symbol and running disparity ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_p1 <= '0;
      cnt_p1 <= CNT_ZERO;
    end else begin
      sym_p1 <= sym_nxt;
      cnt_p1 <= cnt_nxt;
    end
  end

  assign sym  = sym_p1;
  assign disp = cnt_p1;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// Multi-lane TMDS encoder: shared valid/mode pipeline plus one tmds_lane_enc per
// colour lane; symbols appear two cycles after the word is sampled.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  tmds_encoder_pipe_if.slave bus
);

  logic                      vld_p0;
  logic                      vld_p1;
  tmds_mode_e                mode_p0;
  logic [CHANNELS*10-1:0]    sym_all;
  logic [CHANNELS*CNT_W-1:0] disp_all;

  // ---- stage A: valid and mode, shared by all lanes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    mode_p0 <= tmds_mode_e'(bus.in_mode);
  end

  // ---- stage B: output valid ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    tmds_lane_enc #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .data    (bus.in_data[8*k +: 8]),
      .ctrl    (bus.in_ctrl[2*k +: 2]),
      .vld_p0  (vld_p0),
      .mode_p0 (mode_p0),
      .sym     (sym_all[10*k +: 10]),
      .disp    (disp_all[CNT_W*k +: CNT_W])
    );
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = sym_all;
  assign bus.out_disp  = disp_all;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Bench for tmds_encoder_pipe: hand-computed vector table for the directed
// scenarios, then random traffic against a behavioural TMDS model.
module tb_tmds_encoder_pipe;

  localparam int CH = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmds_encoder_pipe_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  tmds_encoder_pipe #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        mode;
    logic [23:0] data;
    logic [5:0]  ctrl;
  } in_t;

  typedef struct {
    in_t         in;
    logic        ev;
    logic [29:0] ed;
    logic [14:0] ep;
  } vec_t;

  int checks = 0;
  int errors = 0;

  in_t        pend[$];
  vec_t       vecs[$];
  logic       m_valid;
  logic [9:0] m_sym  [CH];
  int         m_disp [CH];

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int wrap(input int v);
    int r;
    r = ((v % 32) + 32) % 32;
    if (r >= 16) r = r - 32;
    return r;
  endfunction

  function automatic in_t idle();
    in_t w;
    w.rst = 1'b0; w.valid = 1'b0; w.mode = 1'b0; w.data = '0; w.ctrl = '0;
    return w;
  endfunction

  // Encode the word that has just left the first stage, lane by lane.
  task automatic model_step(input in_t w);
    logic [7:0] d;
    logic [8:0] q;
    logic [9:0] s;
    int ones, n1, n0, c;
    bit xn;
    m_valid = w.valid;
    if (!w.valid) return;
    for (int k = 0; k < CH; k++) begin
      d = w.data[8*k +: 8];
      c = m_disp[k];
      if (w.mode) begin
        s = token(w.ctrl[2*k +: 2]);
        c = 0;
      end else begin
        ones = $countones(d);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (c == 0 || n1 == n0) begin
          s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
          c = c + (q[8] ? (n1 - n0) : (n0 - n1));
        end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
          s = {1'b1, q[8], ~q[7:0]};
          c = c + 2 * int'(q[8]) + (n0 - n1);
        end else begin
          s = {1'b0, q[8], q[7:0]};
          c = c + (n1 - n0) - 2 * int'(!q[8]);
        end
      end
      m_sym[k]  = s;
      m_disp[k] = wrap(c);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input in_t w);
    logic [29:0] md;
    logic [14:0] mp;
    rst          = w.rst;
    bus.in_valid = w.valid;
    bus.in_mode  = w.mode;
    bus.in_data  = w.data;
    bus.in_ctrl  = w.ctrl;
    @(posedge clk);
    if (w.rst) begin
      m_valid = 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_sym[k]  = '0;
        m_disp[k] = 0;
      end
      pend.delete();
      pend.push_back(idle());
    end else begin
      model_step(pend.pop_front());
      pend.push_back(w);
    end
    @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      md[10*k +: 10] = m_sym[k];
      mp[CW*k +: CW] = CW'(m_disp[k]);
    end
    check("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("model_out_data",  32'(bus.out_data),  32'(md));
    check("model_out_disp",  32'(bus.out_disp),  32'(mp));
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic m,
                              input logic [23:0] d, input logic [5:0] c, input logic ev,
                              input logic [9:0] s2, input logic [9:0] s1, input logic [9:0] s0,
                              input logic [4:0] p2, input logic [4:0] p1, input logic [4:0] p0);
    vec_t x;
    x.in.rst = r; x.in.valid = v; x.in.mode = m; x.in.data = d; x.in.ctrl = c;
    x.ev = ev;
    x.ed = {s2, s1, s0};
    x.ep = {p2, p1, p0};
    return x;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    in_t w;
    pend.push_back(idle());
    m_valid = 1'b0;
    for (int k = 0; k < CH; k++) begin
      m_sym[k]  = '0;
      m_disp[k] = 0;
    end

    // Expected outputs on each row belong to the word applied on the previous row.
    //              rst vld mode data          ctrl       ev  lane2  lane1  lane0  d2     d1     d0
    vecs.push_back(mk(1, 1, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(1, 1, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 1, 1, 24'h000000, 6'b110100, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 1, 0, 24'h00FF00, 6'b000000, 1, 10'h2AB, 10'h0AB, 10'h354, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 1, 0, 24'h00FF00, 6'b000000, 1, 10'h100, 10'h200, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 1, 10'h3FF, 10'h0FF, 10'h3FF, 5'h02, 5'h1E, 5'h02));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h3FF, 10'h0FF, 10'h3FF, 5'h02, 5'h1E, 5'h02));
    vecs.push_back(mk(0, 1, 1, 24'h000000, 6'b000000, 0, 10'h3FF, 10'h0FF, 10'h3FF, 5'h02, 5'h1E, 5'h02));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 6'b000000, 1, 10'h354, 10'h354, 10'h354, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 1, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 6'b000000, 0, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 1, 1, 24'h000000, 6'b000000, 1, 10'h3FF, 10'h3FF, 10'h3FF, 5'h02, 5'h02, 5'h02));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 6'b000000, 1, 10'h354, 10'h354, 10'h354, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 1, 1, 24'h000000, 6'b000000, 1, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 6'b000000, 1, 10'h354, 10'h354, 10'h354, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 1, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 6'b000000, 0, 10'h100, 10'h100, 10'h100, 5'h18, 5'h18, 5'h18));
    vecs.push_back(mk(1, 1, 0, 24'hFFFFFF, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));
    vecs.push_back(mk(0, 0, 0, 24'h000000, 6'b000000, 0, 10'h000, 10'h000, 10'h000, 5'h00, 5'h00, 5'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].in);
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].ed));
      check($sformatf("vec%0d_out_disp", i),  32'(bus.out_disp),  32'(vecs[i].ep));
    end

    // Random traffic with mixed modes, bubbles, skewed bytes and rare resets.
    for (int n = 0; n < 1500; n++) begin
      w.rst   = ($urandom_range(0, 99) == 0);
      w.valid = ($urandom_range(0, 3) != 0);
      w.mode  = ($urandom_range(0, 4) == 0);
      w.ctrl  = 6'($urandom);
      for (int k = 0; k < CH; k++) begin
        case ($urandom_range(0, 3))
          0:       w.data[8*k +: 8] = 8'h00;
          1:       w.data[8*k +: 8] = 8'hFF;
          default: w.data[8*k +: 8] = 8'($urandom);
        endcase
      end
      tick(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
